// File: rtl/elevator_call_panel.sv
// Hall call panel: synchronizes and debounces per-floor call buttons, latches call lamps,
// and emits one-cycle request pulses to the elevator controller.
module elevator_call_panel #(
    parameter int unsigned FLOORS          = 5,
    parameter int unsigned POS_W           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] btn_raw,
    input  logic [POS_W-1:0]  floor_pos,
    input  logic              door_open,
    output logic [FLOORS-1:0] floor_req,
    output logic [FLOORS-1:0] call_lamp,
    output logic [POS_W:0]    call_count
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned COUNT_W = POS_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // A single stable sample is enough: skip the wait states entirely.
    localparam logic ONE_SHOT = (DEBOUNCE_CYCLES <= 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    logic [FLOORS-1:0] sync_q;
    logic [FLOORS-1:0] btn_s;
    db_state_t         state_q [FLOORS];
    logic [CNT_W-1:0]  cnt_q   [FLOORS];

    logic [FLOORS-1:0]  accept_c;
    logic [FLOORS-1:0]  serve_c;
    logic [FLOORS-1:0]  lamp_next_c;
    logic [FLOORS-1:0]  pulse_c;
    logic [COUNT_W-1:0] count_next_c;

    // Two-flop synchronizer on the raw buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            btn_s  <= '0;
        end else begin
            sync_q <= btn_raw;
            btn_s  <= sync_q;
        end
    end

    // Press accept is decided from the current debounce state, so lamp and pulse land on the same edge.
    always_comb begin
        accept_c = '0;
        for (int i = 0; i < FLOORS; i++) begin
            case (state_q[i])
                IDLE:       accept_c[i] = btn_s[i] && ONE_SHOT;
                PRESS_WAIT: accept_c[i] = btn_s[i] && (cnt_q[i] == CNT_LAST);
                default:    accept_c[i] = 1'b0;
            endcase
        end
    end

    // Per-floor debounce FSMs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FLOORS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < FLOORS; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (btn_s[i]) begin
                            if (ONE_SHOT) begin
                                state_q[i] <= HELD;
                                cnt_q[i]   <= '0;
                            end else begin
                                state_q[i] <= PRESS_WAIT;
                                cnt_q[i]   <= CNT_W'(1);
                            end
                        end
                    end
                    PRESS_WAIT: begin
                        if (!btn_s[i]) begin
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i] <= HELD;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!btn_s[i]) begin
                            if (ONE_SHOT) begin
                                state_q[i] <= IDLE;
                                cnt_q[i]   <= '0;
                            end else begin
                                state_q[i] <= RELEASE_WAIT;
                                cnt_q[i]   <= CNT_W'(1);
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (btn_s[i]) begin
                            state_q[i] <= HELD;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Service at the current floor both clears the lamp and swallows a new press there.
    always_comb begin
        serve_c = '0;
        for (int i = 0; i < FLOORS; i++) begin
            serve_c[i] = door_open && (floor_pos == POS_W'(i));
        end
        lamp_next_c  = (call_lamp | accept_c) & ~serve_c;
        pulse_c      = accept_c & ~call_lamp & ~serve_c;
        count_next_c = '0;
        for (int i = 0; i < FLOORS; i++) begin
            count_next_c = count_next_c + COUNT_W'(lamp_next_c[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            floor_req  <= '0;
            call_lamp  <= '0;
            call_count <= '0;
        end else begin
            floor_req  <= pulse_c;
            call_lamp  <= lamp_next_c;
            call_count <= count_next_c;
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Self-checking bench for elevator_call_panel: directed scenarios plus randomized
// button/service traffic compared against a run-length behavioural model.
module tb_elevator_call_panel;

    localparam int unsigned FLOORS = 5;
    localparam int unsigned POS_W  = 3;
    localparam int unsigned DC     = 4;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic [FLOORS-1:0] btn_raw   = '0;
    logic [POS_W-1:0]  floor_pos = 3'd7;
    logic              door_open = 1'b0;
    logic [FLOORS-1:0] floor_req;
    logic [FLOORS-1:0] call_lamp;
    logic [POS_W:0]    call_count;

    int checks   = 0;
    int failures = 0;

    elevator_call_panel #(
        .FLOORS         (FLOORS),
        .POS_W          (POS_W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .floor_pos (floor_pos),
        .door_open (door_open),
        .floor_req (floor_req),
        .call_lamp (call_lamp),
        .call_count(call_count)
    );

    always #5 clk = ~clk;

    // Reference: two-stage sample delay, then a debounced level that flips after DC
    // consecutive samples disagreeing with it; a 0->1 flip is an accepted press.
    logic [FLOORS-1:0] m_s1, m_s2, m_lvl, m_req, m_lamp, m_acc;
    int                m_run [FLOORS];
    int                m_count;
    logic              m_serve;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_req = '0; m_lamp = '0; m_acc = '0;
            for (int i = 0; i < FLOORS; i++) m_run[i] = 0;
            m_count = 0;
        end else begin
            m_acc = '0;
            for (int i = 0; i < FLOORS; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= DC) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        m_acc[i] = m_s2[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            for (int i = 0; i < FLOORS; i++) begin
                m_serve  = door_open && (int'(floor_pos) == i);
                m_req[i] = m_acc[i] && !m_lamp[i] && !m_serve;
                if (m_serve) m_lamp[i] = 1'b0;
                else if (m_acc[i]) m_lamp[i] = 1'b1;
            end
            m_count = $countones(m_lamp);
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; btn_raw = '0; door_open = 1'b0; floor_pos = 3'd7;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (floor_req !== 5'b0) begin failures++; $display("FAIL reset_req: got %b expected %b", floor_req, 5'b0); end
        checks++; if (call_lamp !== 5'b0) begin failures++; $display("FAIL reset_lamp: got %b expected %b", call_lamp, 5'b0); end
        checks++; if (call_count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", call_count); end
        reset = 1'b0;
        btn_raw = 5'b00100;
        repeat (8) tick;
        checks++; if (call_lamp !== 5'b00100) begin failures++; $display("FAIL pre_async_lamp: got %b expected %b", call_lamp, 5'b00100); end
        reset = 1'b1;
        #1;
        checks++; if (call_lamp !== 5'b0) begin failures++; $display("FAIL async_reset_lamp: got %b expected %b", call_lamp, 5'b0); end
        checks++; if (call_count !== 4'd0) begin failures++; $display("FAIL async_reset_count: got %0d expected 0", call_count); end
        btn_raw = '0;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_clean_press;
        do_reset;
        btn_raw = 5'b00100;
        for (int k = 0; k <= 6; k++) begin
            tick;
            checks++;
            if (floor_req !== ((k == 5) ? 5'b00100 : 5'b00000)) begin
                failures++; $display("FAIL clean_req edge %0d: got %b expected %b", k, floor_req, (k == 5) ? 5'b00100 : 5'b00000);
            end
            checks++;
            if (call_lamp !== ((k >= 5) ? 5'b00100 : 5'b00000)) begin
                failures++; $display("FAIL clean_lamp edge %0d: got %b expected %b", k, call_lamp, (k >= 5) ? 5'b00100 : 5'b00000);
            end
        end
        checks++; if (call_count !== 4'd1) begin failures++; $display("FAIL clean_count: got %0d expected 1", call_count); end
        btn_raw = '0;
        repeat (8) tick;
    endtask

    task automatic test_bounce;
        int pulses = 0;
        int at = -1;
        do_reset;
        for (int k = 0; k < 15; k++) begin
            btn_raw[1] = (k == 0 || k == 2 || k >= 4);
            tick;
            if (floor_req[1]) begin pulses++; at = k; end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
        checks++; if (at != 9) begin failures++; $display("FAIL bounce_edge: got %0d expected 9", at); end
        checks++; if (call_lamp !== 5'b00010) begin failures++; $display("FAIL bounce_lamp: got %b expected %b", call_lamp, 5'b00010); end
        btn_raw = '0;
        repeat (8) tick;
    endtask

    task automatic test_service_clear;
        do_reset;
        btn_raw = 5'b01010;
        repeat (8) tick;
        btn_raw = '0;
        checks++; if (call_lamp !== 5'b01010) begin failures++; $display("FAIL svc_pre_lamp: got %b expected %b", call_lamp, 5'b01010); end
        checks++; if (call_count !== 4'd2) begin failures++; $display("FAIL svc_pre_count: got %0d expected 2", call_count); end
        floor_pos = 3'd3; door_open = 1'b1;
        tick;
        floor_pos = 3'd7; door_open = 1'b0;
        checks++; if (call_lamp !== 5'b00010) begin failures++; $display("FAIL svc_lamp: got %b expected %b", call_lamp, 5'b00010); end
        checks++; if (call_count !== 4'd1) begin failures++; $display("FAIL svc_count: got %0d expected 1", call_count); end
        repeat (8) tick;
    endtask

    task automatic test_served_press;
        int seen = 0;
        do_reset;
        floor_pos = 3'd0; door_open = 1'b1;
        btn_raw = 5'b00001;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (floor_req !== 5'b0) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL served_req: got %0d pulse cycles expected 0", seen); end
        checks++; if (call_lamp[0] !== 1'b0) begin failures++; $display("FAIL served_lamp: got %b expected 0", call_lamp[0]); end
        btn_raw = '0;
        repeat (8) tick;
        door_open = 1'b0; floor_pos = 3'd7;
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        int seen = 0;
        int at = -1;
        do_reset;
        for (int k = 0; k < 34; k++) begin
            btn_raw = (k < 8 || (k >= 18 && k < 26)) ? 5'b10000 : 5'b00000;
            tick;
            if (floor_req[4]) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL repress_pulses: got %0d expected 1", pulses); end
        checks++; if (call_lamp !== 5'b10000) begin failures++; $display("FAIL repress_lamp: got %b expected %b", call_lamp, 5'b10000); end
        do_reset;
        btn_raw = 5'b10001;
        for (int k = 0; k <= 6; k++) begin
            tick;
            if (floor_req === 5'b10001) begin seen++; at = k; end
        end
        checks++; if (seen != 1) begin failures++; $display("FAIL simul_pulses: got %0d expected 1", seen); end
        checks++; if (at != 5) begin failures++; $display("FAIL simul_edge: got %0d expected 5", at); end
        checks++; if (call_count !== 4'd2) begin failures++; $display("FAIL simul_count: got %0d expected 2", call_count); end
        btn_raw = '0;
        repeat (8) tick;
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        int at = -1;
        do_reset;
        btn_raw = 5'b01000;
        repeat (4) tick;
        reset = 1'b1;
        #1;
        checks++; if ({floor_req, call_lamp} !== 10'b0) begin failures++; $display("FAIL mid_reset_async: got %b expected 0", {floor_req, call_lamp}); end
        tick; tick;
        checks++; if ({floor_req, call_lamp, call_count} !== 14'b0) begin failures++; $display("FAIL mid_reset_held: got %b expected 0", {floor_req, call_lamp, call_count}); end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (floor_req[3]) begin pulses++; at = k; end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL mid_pulses: got %0d expected 1", pulses); end
        checks++; if (at != 5) begin failures++; $display("FAIL mid_edge: got %0d expected 5", at); end
        btn_raw = '0;
        repeat (8) tick;
    endtask

    task automatic test_random;
        int bad = 0;
        do_reset;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < FLOORS; i++) begin
                if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
            end
            door_open = ($urandom_range(0, 7) == 0);
            floor_pos = POS_W'($urandom_range(0, 7));
            tick;
            checks++;
            if (floor_req !== m_req) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_req cycle %0d: got %b expected %b", k, floor_req, m_req);
            end
            checks++;
            if (call_lamp !== m_lamp) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_lamp cycle %0d: got %b expected %b", k, call_lamp, m_lamp);
            end
            checks++;
            if (int'(call_count) != m_count) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_count cycle %0d: got %0d expected %0d", k, call_count, m_count);
            end
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_service_clear;
        test_served_press;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_call_panel.md
ELEVATOR_CALL_PANEL -- requirements
Module: elevator_call_panel

Interface
REQ-001 SHALL have parameter FLOORS, default 5, number of floors / call buttons.
REQ-002 SHALL have parameter POS_W, default 3, width of floor index.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, range 1..255; consecutive synchronized samples needed to accept a press or a release.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port btn_raw, input, FLOORS, asynchronous, bouncing call buttons; bit i belongs to floor i.
REQ-007 SHALL have port floor_pos, input, POS_W, current floor from the elevator controller.
REQ-008 SHALL have port door_open, input, 1, controller door-open indicator.
REQ-009 SHALL have port floor_req, output, FLOORS, registered one-cycle call pulses to the controller request bitmask.
REQ-010 SHALL have port call_lamp, output, FLOORS, registered lamp per floor; lit while that call is outstanding.
REQ-011 SHALL have port call_count, output, POS_W+1, registered number of lit lamps.

Function
REQ-012 SHALL pass each btn_raw bit through a two-flop synchronizer; the second-flop output is btn_s[i], and only btn_s feeds the logic.
REQ-013 SHALL give each floor its own debounce FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT and an 8-bit counter.
REQ-014 IDLE: btn_s=1 -> PRESS_WAIT, counter=1 (DEBOUNCE_CYCLES=1: go straight to HELD and accept).
REQ-015 PRESS_WAIT: btn_s=0 -> IDLE, counter=0; btn_s=1 and counter=DEBOUNCE_CYCLES-1 -> HELD and accept the press; otherwise increment the counter.
REQ-016 HELD: btn_s=0 -> RELEASE_WAIT, counter=1; holding a button never produces a second accept.
REQ-017 RELEASE_WAIT: btn_s=1 -> HELD, counter=0; btn_s=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; otherwise increment the counter.
REQ-018 Timing: a press is accepted on clock edge DEBOUNCE_CYCLES+1, counting the edge that first samples btn_raw[i]=1 as edge 0, when btn_raw is stable high.
REQ-019 Accepted press, when call_lamp[i]=0 and the floor is not being served: set call_lamp[i] and assert floor_req[i] high for exactly one cycle, both from the same edge.
REQ-020 Accepted press when call_lamp[i]=1: no pulse, lamp unchanged.
REQ-021 Floor i is "being served" when door_open=1 and floor_pos=i; an accepted press then produces no pulse and no lamp.
REQ-022 Lamp clear: call_lamp[i] SHALL clear on the edge where door_open=1 and floor_pos=i are sampled.
REQ-023 A clear and an accept on the same floor in the same cycle: the clear wins; the lamp ends 0 with no pulse.
REQ-024 floor_pos>=FLOORS clears nothing and blocks nothing.
REQ-025 Several floors may pulse in the same cycle; the floors are independent.
REQ-026 call_count SHALL equal the popcount of call_lamp in the same cycle; it is computed from the next-lamp vector and registered.
REQ-027 floor_req SHALL be 0 in every cycle with no accept.

Reset
REQ-028 On reset assertion, immediately and asynchronously: synchronizer flops=0, all FSMs=IDLE, counters=0, floor_req=0, call_lamp=0, call_count=0.
REQ-029 Reset during PRESS_WAIT or RELEASE_WAIT SHALL abort the debounce.
REQ-030 After reset release, a button still held high SHALL go through the full debounce and be accepted once, per REQ-018.

Verification
REQ-031 Clean press: btn_raw[2] high from edge 0, DEBOUNCE_CYCLES=4 -> floor_req=5'b00100 for one cycle after edge 5; call_lamp[2]=1; call_count=1.
REQ-032 Bounce: btn_raw[1] toggles 1,0,1,0, then stays high -> exactly one floor_req[1] pulse, 5 cycles after the last rising sample.
REQ-033 Service clear: lamps 1 and 3 lit; drive floor_pos=3, door_open=1 for one cycle -> call_lamp=5'b00010 and call_count=1 on the next cycle.
REQ-034 Press at served floor: floor_pos=0, door_open=1 held throughout; press button 0 -> no floor_req pulse; call_lamp[0]=0.
REQ-035 Re-press and simultaneous: press floor 4 twice, with the second press after a full release -> one pulse only; floors 0 and 4 pressed together -> floor_req=5'b10001 in one cycle.
REQ-036 Reset mid-debounce: assert reset 2 cycles into PRESS_WAIT, release it, keep the button high -> all outputs 0 during reset; one pulse DEBOUNCE_CYCLES+1 edges after release.
